// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - four-function calculator control FSM with shift-add multiplier
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   clr_p             : clear pulse (highest priority)
//   eq_p              : equals pulse
//   add_p/sub_p/mul_p : operator pulses
//   sw[7:0]           : operand level
//   result[15:0]      : registered result magnitude
//   neg               : result is negative (subtraction underflow)
//   ovf               : chained operand truncated
//   busy              : high while in CALC
//   done              : one-cycle completion pulse
//   state[2:0]        : IDLE=0, WAIT_B=1, CALC=2, DONE=3
//
// Optional feature: CALC_CHAIN_EN - an operator pulse in DONE reuses the
// previous result as operand A instead of sampling sw.
module calc_ctrl #(
  parameter int MUL_STEPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_p,
  input  logic        add_p,
  input  logic        sub_p,
  input  logic        mul_p,
  input  logic        eq_p,
  input  logic [7:0]  sw,
  output logic [15:0] result,
  output logic        neg,
  output logic        ovf,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_B = 3'd1,
    S_CALC   = 3'd2,
    S_DONE   = 3'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] result_q, result_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic        fin_q, fin_d;
  logic        done_q, done_d;

  logic        op_any;
  logic [1:0]  op_sel;
  logic [15:0] mul_add;

  // Operator priority: mul > sub > add.
  assign op_any = add_p | sub_p | mul_p;
  assign op_sel = mul_p ? OP_MUL : (sub_p ? OP_SUB : OP_ADD);

  // Partial product for the current multiplier bit, LSB first.
  assign mul_add = b_q[cnt_q] ? ({8'd0, a_q} << cnt_q) : 16'd0;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    fin_d    = 1'b0;
    done_d   = 1'b0;

    if (clr_p) begin
      state_d  = S_IDLE;
      result_d = 16'd0;
      neg_d    = 1'b0;
      ovf_d    = 1'b0;
      cnt_d    = 3'd0;
      acc_d    = 16'd0;
    end else begin
      // done trails DONE entry by one cycle so result is long settled.
      done_d = fin_q;
      case (state_q)
        S_IDLE: begin
          // eq_p outranks operators, and is itself ignored here.
          if (!eq_p && op_any) begin
            a_d     = sw;
            op_d    = op_sel;
            state_d = S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (eq_p) begin
            b_d     = sw;
            cnt_d   = 3'd0;
            acc_d   = 16'd0;
            state_d = S_CALC;
          end else if (op_any) begin
            op_d = op_sel;
          end
        end
        S_CALC: begin
          case (op_q)
            OP_ADD: begin
              result_d = {8'd0, a_q} + {8'd0, b_q};
              neg_d    = 1'b0;
              fin_d    = 1'b1;
              state_d  = S_DONE;
            end
            OP_SUB: begin
              if (a_q >= b_q) begin
                result_d = {8'd0, a_q - b_q};
                neg_d    = 1'b0;
              end else begin
                result_d = {8'd0, b_q - a_q};
                neg_d    = 1'b1;
              end
              fin_d   = 1'b1;
              state_d = S_DONE;
            end
            default: begin
              acc_d = acc_q + mul_add;
              cnt_d = cnt_q + 3'd1;
              if (cnt_q == 3'(MUL_STEPS - 1)) begin
                result_d = acc_q + mul_add;
                neg_d    = 1'b0;
                fin_d    = 1'b1;
                state_d  = S_DONE;
              end
            end
          endcase
        end
        S_DONE: begin
          if (!eq_p && op_any) begin
            op_d    = op_sel;
            state_d = S_WAIT_B;
`ifdef CALC_CHAIN_EN
            a_d   = result_q[7:0];
            ovf_d = (|result_q[15:8]) | neg_q;
            neg_d = 1'b0;
`else
            a_d   = sw;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      op_q     <= OP_ADD;
      cnt_q    <= 3'd0;
      acc_q    <= 16'd0;
      result_q <= 16'd0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == S_CALC);
  assign done   = done_q;
  assign state  = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - directed self-checking bench for calc_ctrl
module tb_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_p = 1'b0;
  logic        add_p = 1'b0;
  logic        sub_p = 1'b0;
  logic        mul_p = 1'b0;
  logic        eq_p = 1'b0;
  logic [7:0]  sw = 8'd0;
  logic [15:0] result;
  logic        neg;
  logic        ovf;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass = 0;

  calc_ctrl #(.MUL_STEPS(8)) dut (
    .clk(clk), .rst(rst), .clr_p(clr_p), .add_p(add_p), .sub_p(sub_p),
    .mul_p(mul_p), .eq_p(eq_p), .sw(sw), .result(result), .neg(neg),
    .ovf(ovf), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0=add 1=sub 2=mul 3=clr
  task automatic pulse(input int which, input logic [7:0] v);
    sw = v;
    case (which)
      0: add_p = 1'b1;
      1: sub_p = 1'b1;
      2: mul_p = 1'b1;
      default: clr_p = 1'b1;
    endcase
    tick();
    add_p = 1'b0; sub_p = 1'b0; mul_p = 1'b0; clr_p = 1'b0;
  endtask

  task automatic do_eq(input logic [7:0] v);
    sw = v;
    eq_p = 1'b1;
    tick();
    eq_p = 1'b0;
  endtask

  // Cycles after the eq_p edge until done is seen; -1 if never within 20.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done && cyc < 0) begin
        cyc = i;
        break;
      end
    end
  endtask

  int cyc;
  int busy_cnt;
  int done_at;
  int done_cnt;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_result", result, 0);
    check("rst_flags", {neg, ovf, busy, done}, 0);

    // 12 + 34
    pulse(0, 8'd12);
    check("add_wait_b", state, 1);
    do_eq(8'd34);
    check("add_busy", busy, 1);
    tick();
    check("add_done_k1", done, 0);
    check("add_state_k1", state, 3);
    tick();
    check("add_done_k2", done, 1);
    check("add_result", result, 46);
    check("add_neg", neg, 0);
    tick();
    check("add_done_once", done, 0);

    // 5 - 9 -> 4 negative
    pulse(3, 8'd0);
    pulse(1, 8'd5);
    do_eq(8'd9);
    wait_done(cyc);
    check("sub_lat", cyc, 2);
    check("sub_result", result, 4);
    check("sub_neg", neg, 1);

    // operator replaced in WAIT_B, A unchanged: 10 - 4
    pulse(3, 8'd0);
    pulse(0, 8'd10);
    pulse(1, 8'd99);
    do_eq(8'd4);
    wait_done(cyc);
    check("repl_result", result, 6);
    check("repl_neg", neg, 0);

    // mul outranks add in the same cycle: 10 * 3
    pulse(3, 8'd0);
    sw = 8'd10; mul_p = 1'b1; add_p = 1'b1;
    tick();
    mul_p = 1'b0; add_p = 1'b0;
    do_eq(8'd3);
    wait_done(cyc);
    check("prio_result", result, 30);

    // 255 * 255: busy 8 cycles, done 9 after eq_p
    pulse(3, 8'd0);
    pulse(2, 8'd255);
    do_eq(8'd255);
    busy_cnt = busy ? 1 : 0;
    done_at = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) pulse(0, 8'd1);
      else tick();
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = i;
    end
    check("mul_busy", busy_cnt, 8);
    check("mul_lat", done_at, 9);
    check("mul_result", result, 16'hFE01);
    check("mul_neg", neg, 0);

    // clr 3 cycles into a multiply
    pulse(3, 8'd0);
    pulse(2, 8'd255);
    do_eq(8'd255);
    tick();
    tick();
    pulse(3, 8'd0);
    check("clr_state", state, 0);
    check("clr_result", result, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("clr_no_done", done_cnt, 0);

    // eq_p in IDLE ignored; add_p with clr_p stays IDLE
    do_eq(8'd7);
    check("idle_eq", state, 0);
    sw = 8'd77; add_p = 1'b1; clr_p = 1'b1;
    tick();
    add_p = 1'b0; clr_p = 1'b0;
    check("add_clr_idle", state, 0);

    // rst mid-multiply: no done pulse
    pulse(2, 8'd9);
    do_eq(8'd9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("rst_mul_done", done_cnt, 0);
    check("rst_mul_state", state, 0);

`ifndef CALC_CHAIN_EN
    // DONE + operator samples sw: 7 + 8
    pulse(0, 8'd1);
    do_eq(8'd2);
    wait_done(cyc);
    pulse(0, 8'd7);
    do_eq(8'd8);
    wait_done(cyc);
    check("redo_result", result, 15);
    check("redo_ovf", ovf, 0);
`else
    pulse(0, 8'd20);
    do_eq(8'd5);
    wait_done(cyc);
    check("chain_add", result, 25);
    pulse(2, 8'd0);
    do_eq(8'd3);
    wait_done(cyc);
    check("chain_mul", result, 75);
    check("chain_ovf0", ovf, 0);
    pulse(3, 8'd0);
    pulse(2, 8'd200);
    do_eq(8'd2);
    wait_done(cyc);
    check("chain_400", result, 400);
    pulse(0, 8'd0);
    check("chain_ovf1", ovf, 1);
    do_eq(8'd0);
    wait_done(cyc);
    check("chain_a144", result, 144);
`endif

    // rst during WAIT_B with a held result
    pulse(0, 8'd3);
    check("pre_rst_state", state, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wb_rst_state", state, 0);
    check("wb_rst_result", result, 0);
    check("wb_rst_flags", {neg, ovf, busy, done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter: MUL_STEPS, 8, iterations of the shift-add multiplier, equal to operand width; only value 8 is supported.
REQ-002 Port: clk  input  1  system clock; all state updates occur on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: clr_p  input  1  debounced single-cycle Clear pulse (S0).
REQ-005 Port: add_p / sub_p / mul_p  input  1 each  debounced single-cycle operator pulses (S1/S2/S3).
REQ-006 Port: eq_p  input  1  debounced single-cycle Equals pulse (S4).
REQ-007 Port: sw  input  8  debounced unsigned operand level.
REQ-008 Port: result  output  16  registered unsigned result magnitude.
REQ-009 Port: neg  output  1  result is negative (subtraction underflow).
REQ-010 Port: ovf  output  1  chained operand truncated (result > 255 when reused as operand A).
REQ-011 Port: busy  output  1  high while state is CALC.
REQ-012 Port: done  output  1  single-cycle pulse on entry to DONE.
REQ-013 Port: state  output  3  current FSM state code: IDLE=0, WAIT_B=1, CALC=2, DONE=3.

Function
REQ-014 FSM states shall be IDLE, WAIT_B, CALC, DONE; codes 4-7 unreachable, and if entered shall return to IDLE next cycle.
REQ-015 Pulse priority in a single cycle shall be clr_p > eq_p > mul_p > sub_p > add_p; lower-priority pulses in that cycle are ignored.
REQ-016 clr_p in any state shall, next cycle, force IDLE with result=0, neg=0, ovf=0, done=0, and abort any multiply in progress.
REQ-017 IDLE + operator pulse: latch A=sw, latch opcode, go WAIT_B; eq_p in IDLE ignored.
REQ-018 WAIT_B + operator pulse: replace opcode only, A unchanged, stay WAIT_B.
REQ-019 WAIT_B + eq_p: latch B=sw, clear iteration counter, go CALC.
REQ-020 CALC, add: result=A+B zero-extended to 16 bits, neg=0; one CALC cycle.
REQ-021 CALC, sub: if A>=B, result=A-B, neg=0; else result=B-A, neg=1; one CALC cycle.
REQ-022 CALC, mul: 8-iteration LSB-first shift-add, one multiplier bit per cycle; result=A*B exact (max 0xFE01); neg=0.
REQ-023 Latency: eq_p sampled at edge k -> done high during cycle after edge k+2 (add/sub) or edge k+9 (mul); result is stable whenever done=1.
REQ-024 Operator, eq_p, and sw changes during CALC shall be ignored; clr_p is not ignored.
REQ-025 DONE holds result/neg until the next operator or clr_p; eq_p in DONE is ignored.
REQ-026 busy=1 exactly for the CALC cycles; done=1 for exactly one cycle per completed operation.

Reset
REQ-027 rst sampled high at a clock edge shall set state=IDLE, result=0, neg=0, ovf=0, busy=0, done=0, clear A/B/opcode/counter; rst overrides clr_p and all pulses.
REQ-028 rst asserted mid-multiply shall abort without a done pulse.

Configuration
REQ-029 Macro CALC_CHAIN_EN defined: an operator pulse in DONE latches A=result[7:0], sets ovf=1 if result[15:8]!=0 or neg=1 (else ovf=0), latches the opcode, clears neg, and goes to WAIT_B.
REQ-030 CALC_CHAIN_EN undefined: an operator pulse in DONE behaves as in IDLE (A=sw); ovf is constant 0.

Verification
REQ-031 sw=12, add_p; sw=34, eq_p -> result=46, neg=0, done exactly 2 cycles after eq_p.
REQ-032 sw=5, sub_p; sw=9, eq_p -> result=4, neg=1.
REQ-033 sw=255, mul_p; sw=255, eq_p -> busy 8 cycles, result=0xFE01, done 9 cycles after eq_p.
REQ-034 clr_p 3 cycles into a multiply -> state=IDLE next cycle, result=0, no done pulse.
REQ-035 CALC_CHAIN_EN: 20+5 -> 25; mul_p, sw=3, eq_p -> 75, ovf=0; then 200*2=400 followed by add_p -> A=144, ovf=1.
REQ-036 add_p and clr_p in the same cycle in IDLE -> stays IDLE, A not latched; rst during WAIT_B -> all outputs at reset values next cycle.
